// File: rtl/line_buffer_fetch_if.sv
// Line-buffer port of the SDRAM arbiter: read request and status toward the
// arbiter, grant/acknowledge/read data back from it.
interface line_buffer_fetch_if;
  logic         lb_sdram_rd;
  logic [21:0]  lb_sdram_addr;
  logic         lb_sdram_Wait;
  logic         lb_sdram_ac;
  logic [127:0] lb_sdram_data;
  logic         lb_Busy;
  logic         lb_done;

  modport master (
    output lb_sdram_rd, lb_sdram_addr, lb_Busy, lb_done,
    input  lb_sdram_Wait, lb_sdram_ac, lb_sdram_data
  );

  modport slave (
    input  lb_sdram_rd, lb_sdram_addr, lb_Busy, lb_done,
    output lb_sdram_Wait, lb_sdram_ac, lb_sdram_data
  );
endinterface

// File: rtl/line_buffer_fetch.sv
// Ping-pong scanline buffer for VGA scan-out. While the front buffer is being
// displayed, the next row is read from SDRAM into the back buffer one 128-bit
// word at a time. The buffers swap at the end of every line (DrawX == 799).
module line_buffer_fetch #(
  parameter logic [21:0] FB_BASE        = 22'h000000,
  parameter int          WORDS_PER_LINE = 80,
  parameter int          LINE_STRIDE    = 80,
  parameter int          V_TOTAL        = 525,
  parameter int          V_VISIBLE      = 480
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  line_buffer_fetch_if.master bus,
  output logic [15:0]         pixel
);
  localparam int PIX_W     = 16;
  localparam int PIX_PER_W = 128 / PIX_W;
  localparam int H_VISIBLE = WORDS_PER_LINE * PIX_PER_W;
  localparam int H_LAST    = 799;
  localparam int IDX_W     = $clog2(WORDS_PER_LINE);
  localparam int DEPTH     = 2 * WORDS_PER_LINE;
  localparam int AW        = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, YIELD, DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [9:0]           row_q, row_d;
  logic                 front_q;

  logic                 trig;
  logic [10:0]          tgt_sum;
  logic [9:0]           tgt_row;
  logic                 last_word;
  logic                 wr_en;
  logic [21:0]          fetch_addr;
  logic [AW-1:0]        waddr, raddr;
  logic                 vis;
  logic                 vis_q;
  logic [2:0]           lane_q;

  logic [127:0]                     ram [DEPTH];
  logic [PIX_PER_W-1:0][PIX_W-1:0]  word_q;

  // Line trigger and the row two lines ahead, wrapping at the frame end.
  assign trig    = (DrawX == 10'(H_LAST));
  assign tgt_sum = {1'b0, DrawY} + 11'd2;
  assign tgt_row = (tgt_sum >= 11'(V_TOTAL)) ? 10'(tgt_sum - 11'(V_TOTAL)) : tgt_sum[9:0];

  assign last_word  = (idx_q == IDX_W'(WORDS_PER_LINE - 1));
  assign fetch_addr = FB_BASE + 22'(row_q) * 22'(LINE_STRIDE) + 22'(idx_q);

  // A word acked in the trigger cycle belongs to the abandoned row; dropping
  // it keeps it from landing in the buffer that is about to be displayed.
  assign wr_en = (state_q == FETCH) && bus.lb_sdram_ac && !trig;

  // Next-state logic; the line trigger overrides whatever the fetch was doing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    case (state_q)
      FETCH: begin
        if (bus.lb_sdram_ac) begin
          if (last_word) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (bus.lb_sdram_Wait) state_d = YIELD;
          end
        end else if (bus.lb_sdram_Wait) begin
          state_d = YIELD;
        end
      end
      YIELD:   if (!bus.lb_sdram_Wait) state_d = FETCH;
      DONE:    state_d = IDLE;
      default: ;
    endcase
    if (trig) begin
      row_d   = tgt_row;
      idx_d   = '0;
      state_d = (tgt_row < 10'(V_VISIBLE)) ? FETCH : IDLE;
    end
  end

  // Fetch state, word index, row and front-buffer select.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      row_q   <= '0;
      front_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      if (trig) front_q <= ~front_q;
    end
  end

  // Port outputs are decoded from state so rd and Busy react within a cycle.
  assign bus.lb_sdram_rd   = (state_q == FETCH);
  assign bus.lb_Busy       = (state_q == FETCH) && !bus.lb_sdram_Wait;
  assign bus.lb_done       = (state_q == DONE);
  assign bus.lb_sdram_addr = (state_q == FETCH) ? fetch_addr : '0;

  // Buffer 0 sits at offset 0, buffer 1 at WORDS_PER_LINE; back is !front.
  // Columns past the visible width are clamped so the read stays in range.
  assign vis   = (DrawX < 10'(H_VISIBLE)) && (DrawY < 10'(V_VISIBLE));
  assign waddr = (front_q ? AW'(0) : AW'(WORDS_PER_LINE)) + AW'(idx_q);
  assign raddr = (front_q ? AW'(WORDS_PER_LINE) : AW'(0))
               + ((DrawX < 10'(H_VISIBLE)) ? AW'(DrawX[9:3]) : AW'(0));

  // Simple dual-port RAM: back-buffer write, registered front-buffer read.
  always_ff @(posedge clk) begin
    if (wr_en) ram[waddr] <= bus.lb_sdram_data;
    word_q <= ram[raddr];
  end

  // Lane select and blanking qualifier travel alongside the RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      vis_q  <= 1'b0;
      lane_q <= '0;
    end else begin
      vis_q  <= vis;
      lane_q <= DrawX[2:0];
    end
  end

  assign pixel = vis_q ? word_q[lane_q] : '0;
endmodule

// File: tb/tb_line_buffer_fetch.sv
// Bench for line_buffer_fetch: a randomized SDRAM responder feeds the DUT
// and a row/word model predicts request addresses, done pulses and pixels.
module tb_line_buffer_fetch;
  localparam int WPL = 80;
  localparam int VT  = 525;
  localparam int VV  = 480;
  localparam logic [21:0] BASE_B = 22'h3FFFF0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [9:0]   drawx = '0, drawy = '0;
  logic         wait_s = 1'b0, ac = 1'b0;
  logic [127:0] data = '0;
  logic [15:0]  pix0, pix1;

  line_buffer_fetch_if bus0();
  line_buffer_fetch_if bus1();

  assign bus0.lb_sdram_Wait = wait_s;
  assign bus0.lb_sdram_ac   = ac;
  assign bus0.lb_sdram_data = data;
  assign bus1.lb_sdram_Wait = wait_s;
  assign bus1.lb_sdram_ac   = ac;
  assign bus1.lb_sdram_data = data;

  line_buffer_fetch dut (
    .clk(clk), .reset(reset), .DrawX(drawx), .DrawY(drawy), .bus(bus0), .pixel(pix0)
  );
  line_buffer_fetch #(.FB_BASE(BASE_B)) dut_b (
    .clk(clk), .reset(reset), .DrawX(drawx), .DrawY(drawy), .bus(bus1), .pixel(pix1)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  logic        s_rd, s_busy, s_done, s_rd_b, s_busy_b, s_done_b;
  logic [21:0] s_addr, s_addr_b;
  logic [15:0] s_pix, s_pix_b;

  // Model: two buffers of words, which one is displayed, row being fetched.
  logic [127:0] mbuf [2][WPL];
  bit           mfront = 1'b0;
  int           mrow = 0, acks = 0, cur_y = 0;
  logic [21:0]  q_ack[$];
  int           done_cnt, done_at, busy_bad, yield_bad, rd_cnt, busy_cnt;

  function automatic logic [15:0] exp_pix(input int x, input int y);
    logic [127:0] w;
    if (x >= 640 || y >= VV) return 16'h0;
    w = mbuf[int'(mfront)][x / 8];
    return w[(x % 8) * 16 +: 16];
  endfunction

  function automatic logic [21:0] exp_addr(input int i);
    return 22'((mrow * WPL + i) % (1 << 22));
  endfunction

  // One clock: inputs change just after the edge, outputs sampled mid-cycle.
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic w, input logic r);
    @(posedge clk); #1;
    ac = 1'b0; drawx = x; drawy = y; wait_s = w; reset = r;
    @(negedge clk);
    s_rd = bus0.lb_sdram_rd;   s_busy = bus0.lb_Busy;   s_done = bus0.lb_done;
    s_addr = bus0.lb_sdram_addr; s_pix = pix0;
    s_rd_b = bus1.lb_sdram_rd; s_busy_b = bus1.lb_Busy; s_done_b = bus1.lb_done;
    s_addr_b = bus1.lb_sdram_addr; s_pix_b = pix1;
  endtask

  task automatic trig(input int y);
    cur_y = y;
    step(10'd799, 10'(y), 1'b0, 1'b0);
    mfront = ~mfront; mrow = (y + 2) % VT; acks = 0; q_ack.delete();
  endtask

  task automatic peek(input int x, input int y, output logic [15:0] p);
    step(10'(x), 10'(y), 1'b0, 1'b0);
    step(10'd0, 10'(y), 1'b0, 1'b0);
    p = s_pix;
  endtask

  // Responder: ack_every=0 acks at random, wait_at raises Wait once that many
  // words have been acked; with same=1 the rising-Wait cycle also carries an ack.
  task automatic run(input int max_cyc, input int ack_every, input int wait_at,
                     input int wait_len, input bit same, input int stop_acks);
    int gap = 0, wleft = 0;
    bit waited = 0, wnow, wprev = 0, rise, ok;
    done_cnt = 0; done_at = -1; busy_bad = 0; yield_bad = 0; rd_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < max_cyc; c++) begin
      rise = 0;
      if (!waited && wait_at >= 0 && acks == wait_at) begin
        waited = 1; wleft = wait_len; rise = 1;
      end
      wnow = (wleft > 0);
      step(10'd0, 10'(cur_y), wnow, 1'b0);
      if (wleft > 0) wleft--;
      if (s_busy !== (s_rd && !wnow)) busy_bad++;
      if (wprev && wnow && (s_rd || s_busy)) yield_bad++;
      if (s_rd) rd_cnt++;
      if (s_busy) busy_cnt++;
      if (s_done) begin done_cnt++; if (done_at < 0) done_at = acks; end
      ok = (ack_every == 0) ? ($urandom_range(0, 2) != 0) : (gap >= ack_every - 1);
      if (s_rd && ((rise && same) || (!wnow && ok))) begin
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        ac = 1'b1;
        mbuf[int'(!mfront)][acks] = data;
        q_ack.push_back(s_addr);
        acks++; gap = 0;
      end else if (s_rd) begin
        gap++;
      end
      wprev = wnow;
      if (stop_acks >= 0 && acks == stop_acks) break;
    end
  endtask

  task automatic test_reset;
    step(10'd0, 10'd0, 1'b0, 1'b1);
    step(10'd0, 10'd0, 1'b0, 1'b1);
    total++;
    if ({s_rd, s_busy, s_done, s_addr, s_pix} !== '0) begin
      bad++; $display("FAIL reset_a: rd=%b busy=%b done=%b addr=%h pix=%h, want all 0",
                      s_rd, s_busy, s_done, s_addr, s_pix);
    end
    total++;
    if ({s_rd_b, s_busy_b, s_done_b, s_addr_b, s_pix_b} !== '0) begin
      bad++; $display("FAIL reset_b: rd=%b busy=%b done=%b addr=%h pix=%h, want all 0",
                      s_rd_b, s_busy_b, s_done_b, s_addr_b, s_pix_b);
    end
    step(10'd0, 10'd0, 1'b0, 1'b0);
    mfront = 1'b0; acks = 0;
  endtask

  task automatic test_prefetch;
    int nbad = 0;
    logic [15:0] p, e;
    trig(523);
    run(300, 3, -1, 0, 1'b0, -1);
    foreach (q_ack[i]) if (q_ack[i] !== exp_addr(i)) nbad++;
    total++;
    if (nbad != 0 || q_ack.size() != WPL) begin
      bad++; $display("FAIL prefetch_seq: %0d wrong of %0d acked, want 0 wrong of %0d", nbad, q_ack.size(), WPL);
    end
    total++;
    if (busy_bad != 0 || busy_cnt == 0) begin
      bad++; $display("FAIL prefetch_busy: bad=%0d busy_cycles=%0d, want 0 and >0", busy_bad, busy_cnt);
    end
    total++;
    if (done_cnt != 1 || done_at != WPL) begin
      bad++; $display("FAIL prefetch_done: pulses=%0d after %0d acks, want 1 after %0d", done_cnt, done_at, WPL);
    end
    trig(524);
    peek(9, 0, p); e = exp_pix(9, 0);
    total++;
    if (p !== e) begin bad++; $display("FAIL pixel_x9: got %h want %h", p, e); end
    for (int k = 0; k < 6; k++) begin
      int x = $urandom_range(0, 639);
      peek(x, 0, p); e = exp_pix(x, 0);
      total++;
      if (p !== e) begin bad++; $display("FAIL pixel_rand x=%0d: got %h want %h", x, p, e); end
    end
  endtask

  task automatic test_address;
    logic [21:0] e_b;
    trig(10);
    step(10'd0, 10'd10, 1'b0, 1'b0);
    e_b = 22'((int'(BASE_B) + mrow * WPL) % (1 << 22));
    total++;
    if (s_rd_b !== 1'b1 || s_addr_b !== e_b) begin
      bad++; $display("FAIL addr_wrap: rd=%b addr=%h, want 1 and %h", s_rd_b, s_addr_b, e_b);
    end
    total++;
    if (s_rd !== 1'b1 || s_addr !== exp_addr(0)) begin
      bad++; $display("FAIL addr_row12: rd=%b addr=%h, want 1 and %h", s_rd, s_addr, exp_addr(0));
    end
  endtask

  task automatic test_yield;
    int nbad = 0;
    trig(100);
    run(500, 0, 5, 20, 1'b0, -1);
    foreach (q_ack[i]) if (q_ack[i] !== exp_addr(i)) nbad++;
    total++;
    if (nbad != 0 || q_ack.size() != WPL) begin
      bad++; $display("FAIL yield_seq: %0d wrong of %0d acked, want 0 wrong of %0d", nbad, q_ack.size(), WPL);
    end
    total++;
    if (yield_bad != 0 || busy_bad != 0) begin
      bad++; $display("FAIL yield_idle: rd/busy during yield=%0d busy_bad=%0d, want 0 0", yield_bad, busy_bad);
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL yield_done: pulses=%0d want 1", done_cnt); end
  endtask

  task automatic test_ack_wait;
    int nbad = 0, x;
    logic [15:0] p, e;
    trig(200);
    run(500, 2, 7, 10, 1'b1, -1);
    foreach (q_ack[i]) if (q_ack[i] !== exp_addr(i)) nbad++;
    total++;
    if (nbad != 0 || q_ack.size() != WPL) begin
      bad++; $display("FAIL ackwait_seq: %0d wrong of %0d acked, want 0 wrong of %0d", nbad, q_ack.size(), WPL);
    end
    total++;
    if (q_ack.size() <= 8 || q_ack[8] !== exp_addr(8)) begin
      bad++; $display("FAIL ackwait_resume: size=%0d, want word 8 at %h", q_ack.size(), exp_addr(8));
    end
    total++;
    if (yield_bad != 0 || busy_bad != 0 || done_cnt != 1) begin
      bad++; $display("FAIL ackwait_ctl: yield_bad=%0d busy_bad=%0d done=%0d, want 0 0 1", yield_bad, busy_bad, done_cnt);
    end
    trig(250);
    x = 56 + $urandom_range(0, 7);
    peek(x, 201, p); e = exp_pix(x, 201);
    total++;
    if (p !== e) begin bad++; $display("FAIL ackwait_word7 x=%0d: got %h want %h", x, p, e); end
  endtask

  task automatic test_blank;
    logic [15:0] p;
    int ys [2] = '{478, 500};
    foreach (ys[j]) begin
      trig(ys[j]);
      run(20, 1, -1, 0, 1'b0, -1);
      total++;
      if (rd_cnt != 0 || busy_cnt != 0) begin
        bad++; $display("FAIL blank_fetch y=%0d: rd=%0d busy=%0d cycles, want 0 0", ys[j], rd_cnt, busy_cnt);
      end
    end
    for (int k = 0; k < 5; k++) begin
      int x = $urandom_range(0, 639), y = $urandom_range(480, 524);
      peek(x, y, p);
      total++;
      if (p !== 16'h0) begin bad++; $display("FAIL blank_row x=%0d y=%0d: got %h want 0", x, y, p); end
    end
    for (int k = 0; k < 5; k++) begin
      int x = $urandom_range(640, 798), y = $urandom_range(0, 479);
      peek(x, y, p);
      total++;
      if (p !== 16'h0) begin bad++; $display("FAIL blank_col x=%0d y=%0d: got %h want 0", x, y, p); end
    end
  endtask

  task automatic test_abandon;
    int nbad = 0, first_done;
    trig(40);
    run(200, 1, -1, 0, 1'b0, 10);
    first_done = done_cnt;
    trig(41);
    run(200, 1, -1, 0, 1'b0, -1);
    foreach (q_ack[i]) if (q_ack[i] !== exp_addr(i)) nbad++;
    total++;
    if (nbad != 0 || q_ack.size() != WPL) begin
      bad++; $display("FAIL abandon_seq: %0d wrong of %0d acked, want 0 wrong of %0d", nbad, q_ack.size(), WPL);
    end
    total++;
    if (first_done != 0 || done_cnt != 1) begin
      bad++; $display("FAIL abandon_done: first=%0d second=%0d, want 0 1", first_done, done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int nbad = 0;
    trig(30);
    run(200, 1, -1, 0, 1'b0, 40);
    step(10'd0, 10'd30, 1'b0, 1'b1);
    step(10'd0, 10'd30, 1'b0, 1'b0);
    mfront = 1'b0; acks = 0;
    total++;
    if (s_rd !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0) begin
      bad++; $display("FAIL rstmid_drop: rd=%b busy=%b done=%b, want 0 0 0", s_rd, s_busy, s_done);
    end
    run(30, 1, -1, 0, 1'b0, -1);
    total++;
    if (done_cnt != 0 || rd_cnt != 0) begin
      bad++; $display("FAIL rstmid_idle: done=%0d rd=%0d, want 0 0", done_cnt, rd_cnt);
    end
    trig(30);
    run(200, 1, -1, 0, 1'b0, -1);
    foreach (q_ack[i]) if (q_ack[i] !== exp_addr(i)) nbad++;
    total++;
    if (nbad != 0 || q_ack.size() != WPL || done_cnt != 1) begin
      bad++; $display("FAIL rstmid_restart: %0d wrong of %0d, done=%0d, want 0 of %0d, 1", nbad, q_ack.size(), done_cnt, WPL);
    end
  endtask

  initial begin
    test_reset();
    test_prefetch();
    test_address();
    test_yield();
    test_ack_wait();
    test_blank();
    test_abandon();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
